sm3_inpt_arb: RTL and testbench

- Message-granular round-robin arbiter that shares the single SM3 message input port (feeding the padding stage) among NREQ requesters.
- A grant is held from a message's first beat until its last beat (lst) is accepted, so padded blocks are never interleaved.
- Sits between the host-side message sources and the SM3 padding/compression core.

---
 rtl/sm3_inpt_arb.sv | 127 ++++++++++++
 tb/tb_sm3_inpt_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_inpt_arb.sv
// Message-granular round-robin arbiter in front of the SM3 padding core.
// A grant is held from a message's first beat until its lst beat is accepted,
// so blocks from different requesters never interleave.
// Optional per-requester message counters: define SM3_INPT_ARB_MSG_CNT_EN.
module sm3_inpt_arb #(
    parameter int unsigned DW   = 32,
    parameter int unsigned NREQ = 2,
    localparam int unsigned IDW = $clog2(NREQ),
    localparam int unsigned BW  = DW / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*DW-1:0]   req_d,
    input  logic [NREQ-1:0]      req_lst,
    input  logic [NREQ*BW-1:0]   req_be,
    output logic [NREQ-1:0]      req_rdy,
    output logic [DW-1:0]        msg_inpt_d,
    output logic                 msg_inpt_vld,
    output logic                 msg_inpt_lst,
    output logic [BW-1:0]        msg_inpt_be,
    input  logic                 msg_inpt_rdy,
    output logic [IDW-1:0]       gnt_id,
`ifdef SM3_INPT_ARB_MSG_CNT_EN
    output logic                 busy,
    output logic [NREQ*16-1:0]   msg_cnt
`else
    output logic                 busy
`endif
);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;

    logic           g_vld, g_lst, lst_xfer, found;
    logic [DW-1:0]  g_d;
    logic [BW-1:0]  g_be;
    logic [IDW-1:0] idx;
    int unsigned    sum;

    // Signals of the currently granted requester
    always_comb begin
        g_vld    = req_vld[gnt_id_q];
        g_lst    = req_lst[gnt_id_q];
        g_d      = req_d[32'(gnt_id_q) * DW +: DW];
        g_be     = req_be[32'(gnt_id_q) * BW +: BW];
        lst_xfer = (state_q == StBusy) && g_vld && g_lst && msg_inpt_rdy;
    end

    // Next-state: round-robin pick in idle, release on the accepted lst beat
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_id_d = gnt_id_q;
        found    = 1'b0;
        idx      = '0;
        sum      = 0;
        unique case (state_q)
            StIdle: begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    sum = (32'(rr_ptr_q) + k) % NREQ;
                    idx = IDW'(sum);
                    if (!found && req_vld[idx]) begin
                        found    = 1'b1;
                        gnt_id_d = idx;
                    end
                end
                if (found) state_d = StBusy;
            end
            StBusy: begin
                if (lst_xfer) begin
                    state_d  = StIdle;
                    rr_ptr_d = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output mux: pass-through of the granted requester while busy, zeros in idle
    always_comb begin
        req_rdy      = '0;
        msg_inpt_d   = '0;
        msg_inpt_vld = 1'b0;
        msg_inpt_lst = 1'b0;
        msg_inpt_be  = '0;
        if (state_q == StBusy) begin
            req_rdy[gnt_id_q] = msg_inpt_rdy;
            msg_inpt_d        = g_d;
            msg_inpt_vld      = g_vld;
            // lst/be qualified by valid so the core never sees stale framing
            msg_inpt_lst      = g_vld & g_lst;
            msg_inpt_be       = g_vld ? g_be : '0;
        end
    end

    assign busy   = (state_q == StBusy);
    assign gnt_id = gnt_id_q;

    // State, round-robin pointer and grant index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_id_q <= gnt_id_d;
        end
    end

`ifdef SM3_INPT_ARB_MSG_CNT_EN
    // Per-requester count of accepted messages, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            msg_cnt <= '0;
        end else if (lst_xfer) begin
            msg_cnt[32'(gnt_id_q) * 16 +: 16] <= msg_cnt[32'(gnt_id_q) * 16 +: 16] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sm3_inpt_arb.sv
// Directed, table-driven bench for sm3_inpt_arb (DW=32, NREQ=2).
module tb_sm3_inpt_arb;

    localparam int unsigned DW   = 32;
    localparam int unsigned NREQ = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_vld;
    logic [63:0] req_d;
    logic [1:0]  req_lst;
    logic [7:0]  req_be;
    logic [1:0]  req_rdy;
    logic [31:0] msg_inpt_d;
    logic        msg_inpt_vld;
    logic        msg_inpt_lst;
    logic [3:0]  msg_inpt_be;
    logic        msg_inpt_rdy;
    logic        gnt_id;
    logic        busy;
`ifdef SM3_INPT_ARB_MSG_CNT_EN
    logic [31:0] msg_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    sm3_inpt_arb #(.DW(DW), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld      (req_vld),
        .req_d        (req_d),
        .req_lst      (req_lst),
        .req_be       (req_be),
        .req_rdy      (req_rdy),
        .msg_inpt_d   (msg_inpt_d),
        .msg_inpt_vld (msg_inpt_vld),
        .msg_inpt_lst (msg_inpt_lst),
        .msg_inpt_be  (msg_inpt_be),
        .msg_inpt_rdy (msg_inpt_rdy),
        .gnt_id       (gnt_id),
`ifdef SM3_INPT_ARB_MSG_CNT_EN
        .busy         (busy),
        .msg_cnt      (msg_cnt)
`else
        .busy         (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [1:0]  lst;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic        rdy;
        logic [1:0]  e_rdy;
        logic [31:0] e_d;
        logic        e_vld;
        logic        e_lst;
        logic [3:0]  e_be;
        logic        e_gnt;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [1:0] v, input logic [1:0] l,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [3:0] b0, input logic [3:0] b1, input logic rd,
                       input logic [1:0] er, input logic [31:0] ed, input logic ev,
                       input logic el, input logic [3:0] eb, input logic eg,
                       input logic ebz);
        vec_t t;
        t = '{r, v, l, d0, d1, b0, b1, rd, er, ed, ev, el, eb, eg, ebz};
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] l,
                         input logic [63:0] d, input logic [7:0] b, input logic rd);
        rst          = r;
        req_vld      = v;
        req_lst      = l;
        req_d        = d;
        req_be       = b;
        msg_inpt_rdy = rd;
    endtask

`ifdef SM3_INPT_ARB_MSG_CNT_EN
    // Single-beat message from one requester, bounded wait for acceptance
    task automatic send_one(input int idx);
        logic [1:0] m;
        bit done;
        m    = 2'b01 << idx;
        done = 0;
        @(posedge clk); #1;
        drive(1'b0, m, m, 64'h0, 8'hFF, 1'b1);
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if ((req_rdy & m) != 0 && msg_inpt_lst) done = 1;
            @(posedge clk); #1;
        end
        drive(1'b0, 2'b00, 2'b00, 64'h0, 8'h00, 1'b1);
        chk("send_accepted", idx, 32'(done), 32'd1);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Single requester, 3 beats
        add(0,2'b01,2'b00,32'h61626380,0,0,0,1, 2'b00,0,0,0,0,0,0);
        add(0,2'b01,2'b00,32'h61626380,0,0,0,1, 2'b01,32'h61626380,1,0,0,0,1);
        add(0,2'b01,2'b00,32'h0,0,0,0,1,        2'b01,32'h0,1,0,0,0,1);
        add(0,2'b01,2'b01,32'h18,0,4'hF,0,1,    2'b01,32'h18,1,1,4'hF,0,1);
        // rr_ptr now 1: both request, req1 wins; reset while stalled
        add(0,2'b11,2'b00,32'hA0,32'hB0,0,0,1,  2'b00,0,0,0,0,0,0);
        add(0,2'b11,2'b00,32'hA0,32'hB0,0,0,0,  2'b00,32'hB0,1,0,0,1,1);
        add(1,2'b11,2'b00,32'hA0,32'hB0,0,0,0,  2'b00,32'hB0,1,0,0,1,1);
        // After reset rr_ptr=0: contention, req0 first
        add(0,2'b11,2'b00,32'hA0,32'hB0,0,0,1,  2'b00,0,0,0,0,0,0);
        add(0,2'b11,2'b00,32'hA0,32'hB0,0,0,1,  2'b01,32'hA0,1,0,0,0,1);
        add(0,2'b11,2'b01,32'hA1,32'hB0,4'hF,0,1, 2'b01,32'hA1,1,1,4'hF,0,1);
        add(0,2'b11,2'b00,32'hA2,32'hB0,0,0,1,  2'b00,0,0,0,0,0,0);
        add(0,2'b11,2'b00,32'hA2,32'hB0,0,0,1,  2'b10,32'hB0,1,0,0,1,1);
        add(0,2'b11,2'b10,32'hA2,32'hB1,0,4'hF,1, 2'b10,32'hB1,1,1,4'hF,1,1);
        // Fairness: single-beat messages 0 then 1
        add(0,2'b11,2'b00,32'hA2,32'hB2,0,0,1,  2'b00,0,0,0,0,1,0);
        add(0,2'b11,2'b01,32'hA2,32'hB2,4'hF,0,1, 2'b01,32'hA2,1,1,4'hF,0,1);
        add(0,2'b11,2'b00,32'hA3,32'hB2,0,0,1,  2'b00,0,0,0,0,0,0);
        add(0,2'b11,2'b10,32'hA3,32'hB2,0,4'h3,1, 2'b10,32'hB2,1,1,4'h3,1,1);
        // Backpressure: 5 stalled cycles on the lst beat
        add(0,2'b01,2'b00,32'hC0,0,0,0,1,       2'b00,0,0,0,0,1,0);
        add(0,2'b01,2'b00,32'hC0,0,0,0,1,       2'b01,32'hC0,1,0,0,0,1);
        for (int i = 0; i < 5; i++)
            add(0,2'b01,2'b01,32'hC1,0,4'hF,0,0, 2'b00,32'hC1,1,1,4'hF,0,1);
        add(0,2'b01,2'b01,32'hC1,0,4'hF,0,1,    2'b01,32'hC1,1,1,4'hF,0,1);
        add(0,2'b00,2'b00,0,0,0,0,1,            2'b00,0,0,0,0,0,0);
        // Granted requester with vld low: lst/be forced to 0
        add(0,2'b10,2'b10,0,32'hD0,0,4'hF,1,    2'b00,0,0,0,0,0,0);
        add(0,2'b00,2'b10,0,32'hD0,0,4'hF,1,    2'b10,32'hD0,0,0,0,1,1);
        add(0,2'b10,2'b10,0,32'hD0,0,4'hF,1,    2'b10,32'hD0,1,1,4'hF,1,1);
        add(0,2'b00,2'b00,0,0,0,0,1,            2'b00,0,0,0,0,1,0);
        // Reset after the 2nd of 4 beats, then req1 served normally
        add(0,2'b01,2'b00,32'hE0,0,0,0,1,       2'b00,0,0,0,0,1,0);
        add(0,2'b01,2'b00,32'hE0,0,0,0,1,       2'b01,32'hE0,1,0,0,0,1);
        add(0,2'b01,2'b00,32'hE1,0,0,0,1,       2'b01,32'hE1,1,0,0,0,1);
        add(1,2'b01,2'b00,32'hE2,0,0,0,1,       2'b01,32'hE2,1,0,0,0,1);
        add(0,2'b10,2'b00,0,32'hF0,0,0,1,       2'b00,0,0,0,0,0,0);
        add(0,2'b10,2'b10,0,32'hF0,0,4'hF,1,    2'b10,32'hF0,1,1,4'hF,1,1);
        add(0,2'b00,2'b00,0,0,0,0,1,            2'b00,0,0,0,0,1,0);

        drive(1'b1, 2'b00, 2'b00, 64'h0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].lst, {tbl[i].d1, tbl[i].d0},
                  {tbl[i].be1, tbl[i].be0}, tbl[i].rdy);
            @(negedge clk);
            chk("req_rdy", i, 32'(req_rdy), 32'(tbl[i].e_rdy));
            chk("msg_d",   i, msg_inpt_d, tbl[i].e_d);
            chk("msg_vld", i, 32'(msg_inpt_vld), 32'(tbl[i].e_vld));
            chk("msg_lst", i, 32'(msg_inpt_lst), 32'(tbl[i].e_lst));
            chk("msg_be",  i, 32'(msg_inpt_be), 32'(tbl[i].e_be));
            chk("gnt_id",  i, 32'(gnt_id), 32'(tbl[i].e_gnt));
            chk("busy",    i, 32'(busy), 32'(tbl[i].e_busy));
            @(posedge clk); #1;
        end

        // Grant held while req0 stalls mid-message; req1 stays blocked
        drive(1'b0, 2'b01, 2'b00, {32'h0, 32'h11}, 8'h00, 1'b1);
        @(negedge clk);
        chk("hold_idle", 0, 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_first", 0, msg_inpt_d, 32'h11);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 2'b10, 2'b00, {32'h22, 32'h12}, 8'h00, 1'b1);
            @(negedge clk);
            chk("hold_rdy",  i, 32'(req_rdy), 32'h1);
            chk("hold_vld",  i, 32'(msg_inpt_vld), 32'd0);
            chk("hold_gnt",  i, 32'(gnt_id), 32'd0);
            chk("hold_busy", i, 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        drive(1'b0, 2'b11, 2'b01, {32'h22, 32'h12}, 8'h0F, 1'b1);
        @(negedge clk);
        chk("hold_lst", 0, 32'(msg_inpt_lst), 32'd1);
        chk("hold_d",   0, msg_inpt_d, 32'h12);
        @(posedge clk); #1;
        drive(1'b0, 2'b10, 2'b00, {32'h22, 32'h12}, 8'h00, 1'b1);
        @(negedge clk);
        chk("hold_bubble", 0, 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_next_gnt", 0, 32'(gnt_id), 32'd1);
        chk("hold_next_d",   0, msg_inpt_d, 32'h22);
        @(posedge clk); #1;

`ifdef SM3_INPT_ARB_MSG_CNT_EN
        drive(1'b1, 2'b00, 2'b00, 64'h0, 8'h00, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 2'b00, 2'b00, 64'h0, 8'h00, 1'b1);
        @(negedge clk);
        chk("cnt_reset", 0, msg_cnt, 32'h0);
        send_one(1);
        send_one(1);
        send_one(1);
        send_one(0);
        @(negedge clk);
        chk("msg_cnt", 0, msg_cnt, {16'd3, 16'd1});
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
